// File: rtl/avalon_pio_pkg.sv
// Shared types and constants for the Avalon PIO button pollers.
package avalon_pio_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      WAIT = 2'd2,
      EVAL = 2'd3
   } poll_state_t;

   localparam logic [1:0] PIO_DATA_OFFSET = 2'd0;
   localparam int         PIO_DATA_W      = 32;
   localparam logic [3:0] STABLE_MAX      = 4'd15;

   // Saturating increment for the 4-bit stability counter.
   function automatic logic [3:0] stable_inc(input logic [3:0] value);
      logic [3:0] result;
      if (value == STABLE_MAX) begin
         result = STABLE_MAX;
      end else begin
         result = value + 4'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/button_debounce.sv
// Sample-driven debouncer: accepts a new level after DEBOUNCE_COUNT equal
// samples and emits registered one-cycle press/release pulses.
module button_debounce
   import avalon_pio_pkg::*;
#(
   parameter int DEBOUNCE_COUNT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sample_valid,
   input  logic        sample,
   output logic        level,
   output logic        press_pulse,
   output logic        release_pulse,
   output logic [15:0] press_count
);

   localparam logic [3:0] ACCEPT_CNT = 4'(DEBOUNCE_COUNT);

   logic       candidate;
   logic [3:0] stable_cnt;
   logic       next_candidate;
   logic [3:0] next_stable_cnt;
   logic       accept;

   // Next candidate/run length for the incoming sample, and whether it flips the level.
   always_comb begin
      next_candidate  = candidate;
      next_stable_cnt = stable_cnt;
      if (sample == candidate) begin
         next_candidate  = candidate;
         next_stable_cnt = stable_inc(stable_cnt);
      end else begin
         next_candidate  = sample;
         next_stable_cnt = 4'd1;
      end
      accept = (next_stable_cnt >= ACCEPT_CNT) && (next_candidate != level);
   end

   // Debounce state, pulses and press counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         candidate     <= 1'b0;
         stable_cnt    <= 4'd0;
         level         <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         press_count   <= 16'd0;
      end else begin
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         if (sample_valid) begin
            candidate  <= next_candidate;
            stable_cnt <= next_stable_cnt;
            if (accept) begin
               level         <= next_candidate;
               press_pulse   <= next_candidate;
               release_pulse <= ~next_candidate;
               if (next_candidate) begin
                  press_count <= press_count + 16'd1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/avalon_pio_button_poller.sv
// Avalon-MM master that polls a button PIO data register and feeds bit 0
// into a debouncer.
module avalon_pio_button_poller
   import avalon_pio_pkg::*;
#(
   parameter int POLL_PERIOD    = 50000,
   parameter int DEBOUNCE_COUNT = 4,
   parameter int READ_LATENCY   = 1,
   parameter int ACTIVE_LOW     = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   output logic [1:0]            avm_address,
   output logic                  avm_read,
   input  logic                  avm_waitrequest,
   input  logic [PIO_DATA_W-1:0] avm_readdata,
   output logic                  button_level,
   output logic                  press_pulse,
   output logic                  release_pulse,
   output logic [15:0]           press_count
);

   localparam logic [23:0] POLL_RELOAD = 24'(POLL_PERIOD - 1);
   localparam logic [1:0]  LAT_RELOAD  = 2'(READ_LATENCY - 1);
   localparam logic        INVERT      = (ACTIVE_LOW != 0);

   poll_state_t state;
   logic [23:0] poll_cnt;
   logic [23:0] poll_dec;
   logic [1:0]  lat_cnt;
   logic        sample;
   logic        sample_valid;
   logic        unused_data;

   assign avm_address  = PIO_DATA_OFFSET;
   assign sample_valid = (state == EVAL);
   assign unused_data  = ^avm_readdata[PIO_DATA_W-1:1];

   // Poll timer keeps running through a transaction and parks at zero,
   // which is how an overdue poll is deferred to the next IDLE.
   always_comb begin
      if (enable && (poll_cnt != 24'd0)) begin
         poll_dec = poll_cnt - 24'd1;
      end else begin
         poll_dec = poll_cnt;
      end
   end

   // Poll scheduler and read transaction FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         poll_cnt <= POLL_RELOAD;
         lat_cnt  <= 2'd0;
         avm_read <= 1'b0;
         sample   <= 1'b0;
      end else begin
         poll_cnt <= poll_dec;
         case (state)
            IDLE: begin
               if (enable && (poll_cnt == 24'd0)) begin
                  poll_cnt <= POLL_RELOAD;
                  avm_read <= 1'b1;
                  state    <= READ;
               end
            end
            READ: begin
               if (!avm_waitrequest) begin
                  avm_read <= 1'b0;
                  lat_cnt  <= LAT_RELOAD;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (lat_cnt == 2'd0) begin
                  sample <= avm_readdata[0] ^ INVERT;
                  state  <= EVAL;
               end else begin
                  lat_cnt <= lat_cnt - 2'd1;
               end
            end
            EVAL: begin
               state <= IDLE;
            end
            default: begin
               avm_read <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

   button_debounce #(
      .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
   ) u_debounce (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample       (sample),
      .level        (button_level),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .press_count  (press_count)
   );

endmodule

// File: tb/tb_avalon_pio_button_poller.sv
// Randomised self-checking bench for avalon_pio_button_poller against an
// event-level reference model.
module tb_avalon_pio_button_poller;

   localparam int P  = 4;
   localparam int DC = 3;
   localparam int RL = 1;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [1:0]  avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        button_level;
   logic        press_pulse;
   logic        release_pulse;
   logic [15:0] press_count;

   avalon_pio_button_poller #(
      .POLL_PERIOD(P), .DEBOUNCE_COUNT(DC), .READ_LATENCY(RL), .ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .avm_address(avm_address), .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .button_level(button_level), .press_pulse(press_pulse),
      .release_pulse(release_pulse), .press_count(press_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int        m_cnt     = P - 1;
   bit        m_busy    = 1'b0;
   bit        m_reading = 1'b0;
   int        m_cap_in  = -1;
   bit        m_eval    = 1'b0;
   bit        m_s       = 1'b0;
   bit        exp_level = 1'b0;
   bit        exp_press = 1'b0;
   bit        exp_rel   = 1'b0;
   bit [15:0] exp_count = 16'd0;
   bit        hist[$];
   int        polls_done = 0;
   bit        preload_req = 1'b0;

   // Debounce rule: accept when the trailing run of equal samples reaches DC.
   task automatic model_sample(input bit s);
      int run;
      hist.push_back(s);
      if (hist.size() > 16) void'(hist.pop_front());
      run = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i] != s) break;
         run++;
      end
      if (run >= DC && s != exp_level) begin
         exp_level = s;
         if (s) begin
            exp_press = 1'b1;
            exp_count = exp_count + 16'd1;
         end else begin
            exp_rel = 1'b1;
         end
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_cnt = P - 1; m_busy = 1'b0; m_reading = 1'b0; m_cap_in = -1; m_eval = 1'b0;
         exp_level = 1'b0; exp_press = 1'b0; exp_rel = 1'b0; exp_count = 16'd0;
         hist.delete();
      end else begin
         bit was_busy;
         was_busy  = m_busy;
         exp_press = 1'b0;
         exp_rel   = 1'b0;
         if (preload_req) exp_count = 16'hFFFE;
         if (m_eval) begin
            model_sample(m_s);
            m_eval = 1'b0;
            m_busy = 1'b0;
            polls_done++;
         end
         if (m_cap_in == 0) begin
            m_s = avm_readdata[0] ^ 1'b1;
            m_eval = 1'b1;
            m_cap_in = -1;
         end else if (m_cap_in > 0) begin
            m_cap_in--;
         end
         if (m_reading && !avm_waitrequest) begin
            m_reading = 1'b0;
            m_cap_in = RL - 1;
         end
         if (!was_busy) begin
            if (enable) begin
               if (m_cnt == 0) begin
                  m_cnt = P - 1; m_busy = 1'b1; m_reading = 1'b1;
               end else begin
                  m_cnt--;
               end
            end
         end else if (enable && m_cnt > 0) begin
            m_cnt--;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int cyc = 0;
   int first_read_cyc = -1;
   int reads_seen = 0;
   int press_seen = 0;

   always @(posedge clk) if (!reset) cyc++;

   always @(negedge clk) begin
      check("avm_read", avm_read, exp_read());
      check("avm_address", avm_address, 32'd0);
      check("button_level", button_level, exp_level);
      check("press_pulse", press_pulse, exp_press);
      check("release_pulse", release_pulse, exp_rel);
      check("press_count", press_count, exp_count);
      if (avm_read) begin
         reads_seen++;
         if (first_read_cyc < 0) first_read_cyc = cyc;
      end
      if (press_pulse) press_seen++;
   end

   function automatic logic [31:0] exp_read();
      return {31'd0, m_reading};
   endfunction

   // ---------------- stimulus ----------------
   bit raw = 1'b1;

   task automatic set_raw(input bit b);
      raw = b;
      avm_readdata[0] = b;
   endtask

   task automatic step();
      logic [31:0] r;
      @(posedge clk);
      #2;
      r = $urandom();
      avm_readdata = {r[31:1], raw};
   endtask

   task automatic wait_polls(input int n);
      int target;
      target = polls_done + n;
      for (int i = 0; i < 200 && polls_done < target; i++) step();
      if (polls_done < target) check("poll_timeout", polls_done, target);
   endtask

   task automatic wait_model_reading();
      for (int i = 0; i < 40 && !m_reading; i++) step();
      if (!m_reading) check("read_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      int pc0, pd, rs, r0;
      bit pat[8];
      pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      reset = 1'b1;
      enable = 1'b1;
      avm_waitrequest = 1'b0;
      avm_readdata = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      #2 reset = 1'b0;

      // idle polling with button released
      repeat (20) step();
      check("first_read_cycle", first_read_cyc, 32'd4);
      check("idle_level", button_level, 32'd0);

      // held press then release
      set_raw(1'b0);
      wait_polls(3);
      check("press_level", button_level, 32'd1);
      check("press_pulse_lit", press_pulse, 32'd1);
      check("press_count_1", press_count, 32'd1);
      set_raw(1'b1);
      wait_polls(3);
      check("release_pulse_lit", release_pulse, 32'd1);
      check("release_level", button_level, 32'd0);

      // bounce pattern: one press, only after the 8th poll
      pc0 = press_seen;
      for (int i = 0; i < 8; i++) begin
         set_raw(pat[i]);
         wait_polls(1);
         if (i == 6) check("bounce_no_early", press_seen - pc0, 32'd0);
      end
      step();
      check("bounce_one_press", press_seen - pc0, 32'd1);
      check("bounce_count", press_count, 32'd2);
      set_raw(1'b1);
      wait_polls(4);

      // waitrequest stall of 5 cycles
      avm_waitrequest = 1'b1;
      wait_model_reading();
      r0 = reads_seen;
      repeat (5) step();
      avm_waitrequest = 1'b0;
      repeat (4) step();
      check("stall_read_cycles", reads_seen - r0, 32'd6);
      repeat (12) step();

      // enable dropped during WAIT
      for (int i = 0; i < 40 && m_cap_in != 0; i++) step();
      check("reach_wait", m_cap_in, 32'd0);
      enable = 1'b0;
      pd = polls_done;
      rs = reads_seen;
      repeat (25) step();
      check("wait_sample_evaluated", polls_done, pd + 1);
      check("no_read_disabled", reads_seen, rs);
      enable = 1'b1;
      repeat (12) step();

      // randomised traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) set_raw(~raw);
         avm_waitrequest = ($urandom_range(0, 3) == 0);
         enable = ($urandom_range(0, 15) != 0);
         step();
      end
      avm_waitrequest = 1'b0;
      enable = 1'b1;
      set_raw(1'b1);
      wait_polls(4);

      // press counter wrap via preload
      enable = 1'b0;
      for (int i = 0; i < 20 && m_busy; i++) step();
      step();
      @(negedge clk);
      #2;
      force dut.u_debounce.press_count = 16'hFFFE;
      preload_req = 1'b1;
      @(posedge clk);
      #2;
      release dut.u_debounce.press_count;
      preload_req = 1'b0;
      set_raw(1'b0);
      enable = 1'b1;
      wait_polls(3);
      check("count_ffff", press_count, 32'hFFFF);
      set_raw(1'b1);
      wait_polls(3);
      set_raw(1'b0);
      wait_polls(3);
      check("count_wrap", press_count, 32'd0);
      check("wrap_level", button_level, 32'd1);

      // asynchronous reset in the middle of a read
      avm_waitrequest = 1'b1;
      wait_model_reading();
      reset = 1'b1;
      #1;
      check("rst_avm_read", avm_read, 32'd0);
      check("rst_level", button_level, 32'd0);
      check("rst_count", press_count, 32'd0);
      check("rst_pulses", {press_pulse, release_pulse}, 32'd0);
      avm_waitrequest = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      repeat (12) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
